// File: rtl/psk_modulator.sv
// Phase-shift keyed carrier generator: BPSK or Gray-coded QPSK selected per symbol, valid/ready
// symbol input, registered DAC sample output held at midscale between bursts.
module psk_modulator #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned WAVELENGTH        = 32,
  parameter int unsigned CYCLES_PER_SYMBOL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [1:0]            sym_data,
  input  logic                  sym_valid,
  output logic                  sym_ready,
  output logic [DATA_WIDTH-1:0] signal,
  output logic                  sample_valid,
  output logic                  symbol_done,
  output logic                  burst_end
);

  localparam int unsigned N       = WAVELENGTH * CYCLES_PER_SYMBOL;
  localparam int unsigned CntW    = $clog2(N);
  localparam int unsigned SumW    = DATA_WIDTH + 1;
  localparam int unsigned TabSize = 2 ** DATA_WIDTH;

  localparam logic [CntW-1:0]       CntLast = CntW'(N - 1);
  localparam logic [DATA_WIDTH-1:0] Mid     = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] LastPh  = DATA_WIDTH'(WAVELENGTH - 1);
  localparam logic [DATA_WIDTH-1:0] OffQ    = DATA_WIDTH'(WAVELENGTH / 4);
  localparam logic [DATA_WIDTH-1:0] Off2Q   = DATA_WIDTH'(WAVELENGTH / 2);
  localparam logic [DATA_WIDTH-1:0] Off3Q   = DATA_WIDTH'(3 * (WAVELENGTH / 4));
  localparam logic [SumW-1:0]       WaveLen = SumW'(WAVELENGTH);

  // Sine table entry: half-wave rational approximation, amplitude Mid-1, centred on Mid.
  function automatic logic [DATA_WIDTH-1:0] sine_sample(input int k);
    longint h, p, a, num, den, v;
    h   = longint'(WAVELENGTH / 2);
    a   = (longint'(1) << (DATA_WIDTH - 1)) - 1;
    p   = (longint'(k) < h) ? longint'(k) : longint'(k) - h;
    num = 16 * p * (h - p) * a;
    den = 5 * h * h - 4 * p * (h - p);
    v   = (num + den / 2) / den;
    return (longint'(k) < h) ? DATA_WIDTH'(a + 1 + v) : DATA_WIDTH'(a + 1 - v);
  endfunction

  logic [DATA_WIDTH-1:0] w_table [TabSize];

  for (genvar k = 0; k < TabSize; k++) begin : g_table
    if (k < WAVELENGTH) begin : g_wave
      assign w_table[k] = sine_sample(k);
    end else begin : g_pad
      assign w_table[k] = Mid;
    end
  end

  typedef enum logic {StIdle, StRun} state_e;

  state_e                r_state;
  logic [CntW-1:0]       r_cnt;
  logic [DATA_WIDTH-1:0] r_ph;
  logic [DATA_WIDTH-1:0] r_off;
  logic [DATA_WIDTH-1:0] w_new_off;
  logic [DATA_WIDTH-1:0] w_idx;
  logic [SumW-1:0]       w_sum;
  logic                  w_last;
  logic                  w_hs;

  assign w_last    = (r_cnt == CntLast);
  assign sym_ready = enable & ((r_state == StIdle) | w_last);
  assign w_hs      = sym_valid & sym_ready;

  // r_ph tracks cnt mod WAVELENGTH, so the wrap needs only one compare-and-subtract.
  assign w_sum = {1'b0, r_ph} + {1'b0, r_off};
  assign w_idx = (w_sum >= WaveLen) ? DATA_WIDTH'(w_sum - WaveLen) : w_sum[DATA_WIDTH-1:0];

  always_comb begin
    w_new_off = '0;
    if (!mode) begin
      w_new_off = sym_data[0] ? Off2Q : '0;
    end else begin
      case (sym_data)
        2'b01:   w_new_off = OffQ;
        2'b11:   w_new_off = Off2Q;
        2'b10:   w_new_off = Off3Q;
        default: w_new_off = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_ph         <= '0;
      r_off        <= '0;
      signal       <= Mid;
      sample_valid <= 1'b0;
      symbol_done  <= 1'b0;
      burst_end    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          signal       <= Mid;
          sample_valid <= 1'b0;
          symbol_done  <= 1'b0;
          burst_end    <= 1'b0;
          if (w_hs) begin
            r_off   <= w_new_off;
            r_cnt   <= '0;
            r_ph    <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          signal       <= w_table[w_idx];
          sample_valid <= 1'b1;
          if (!w_last) begin
            r_cnt       <= r_cnt + 1'b1;
            r_ph        <= (r_ph == LastPh) ? '0 : r_ph + 1'b1;
            symbol_done <= 1'b0;
            burst_end   <= 1'b0;
          end else begin
            symbol_done <= 1'b1;
            if (w_hs) begin
              r_off     <= w_new_off;
              r_cnt     <= '0;
              r_ph      <= '0;
              burst_end <= 1'b0;
            end else begin
              r_state   <= StIdle;
              burst_end <= 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/psk_modulator.md
Name: psk_modulator

Overview:
Parametrised successor to the single-bit BPSK modulator. It accepts symbols over a valid/ready handshake and supports BPSK or Gray-coded QPSK, selected per symbol. For each symbol it emits a parallel carrier sample stream to the DAC, phase-shifted by the symbol value, and reads samples from the shared wave_table_sine lookup. Between bursts it holds the DAC at midscale, and it flags symbol boundaries and burst ends.

Parameters:
DATA_WIDTH, 8, DAC sample width; also the width of the wave table index and data.
WAVELENGTH, 32, samples per carrier cycle; must be a multiple of 4 and no greater than 2^DATA_WIDTH.
CYCLES_PER_SYMBOL, 1, carrier cycles per symbol; must be at least 1.

Ports:
clk  in  1  sample clock; one sample per cycle.
rst  in  1  asynchronous reset, active high.
enable  in  1  allows new symbols to be accepted; a symbol already in progress always completes.
mode  in  1  0 = BPSK (uses sym_data[0] only), 1 = QPSK; sampled at symbol acceptance.
sym_data  in  2  symbol value.
sym_valid  in  1  sym_data and mode are valid.
sym_ready  out  1  combinational; a symbol is accepted when sym_valid and sym_ready are both high at a rising edge.
signal  out  DATA_WIDTH  registered sample to the DAC.
sample_valid  out  1  registered; high while signal carries modulated data.
symbol_done  out  1  registered one-cycle pulse, coincident with the last sample of each symbol.
burst_end  out  1  registered one-cycle pulse, coincident with the last sample of a symbol when no next symbol was accepted.

Behaviour:
- Let N = WAVELENGTH*CYCLES_PER_SYMBOL, MID = 2^(DATA_WIDTH-1), Q = WAVELENGTH/4.
- Reset (asynchronous, applies immediately, including mid-symbol):
  - state = IDLE; cnt = 0; latched offset = 0.
  - signal = MID; sample_valid, symbol_done and burst_end = 0.
- Phase offset, computed at acceptance from the accepted values:
  - BPSK: sym_data[0] * 2Q.
  - QPSK Gray map: 00 -> 0, 01 -> Q, 11 -> 2Q, 10 -> 3Q.
- Phase index = ((cnt mod WAVELENGTH) + offset) mod WAVELENGTH. Use compare-and-subtract; no divider when WAVELENGTH is not a power of two.
- sym_ready:
  - IDLE: sym_ready = enable.
  - RUN with cnt == N-1: sym_ready = enable.
  - All other cycles: sym_ready = 0.
- IDLE state:
  - Each edge: signal <= MID, sample_valid <= 0, symbol_done <= 0, burst_end <= 0.
  - On handshake: latch offset, cnt <= 0, state <= RUN.
- RUN state, every edge:
  - signal <= table[phase index]; sample_valid <= 1.
  - If cnt < N-1: cnt <= cnt+1; symbol_done <= 0; burst_end <= 0.
  - If cnt == N-1: symbol_done <= 1.
    - With handshake: latch new offset, cnt <= 0, stay in RUN, burst_end <= 0. Back-to-back symbols have zero gap and continuous sample_valid.
    - Without handshake: state <= IDLE, burst_end <= 1.
- Latency: handshake at edge E0 -> first sample (cnt 0) on signal after edge E1. The last sample appears after edge E_N; the MID sample follows one edge later.
- enable low mid-symbol: the symbol finishes all N samples and no new symbol is accepted, so burst_end fires.
- sym_valid is ignored whenever sym_ready is low. sym_data and mode are not sampled outside a handshake.
- The wave table lookup is combinational; the only registering stage is the signal output register.
- cnt width is clog2(N); no overflow is possible because cnt wraps only via the explicit reset to 0.

Test Plan:
- Reset then idle, enable=1, sym_valid=0 for 10 cycles -> signal=128, sample_valid=0, sym_ready=1 throughout.
- BPSK, mode=0, sym_data=0, one symbol (W=32, C=1) -> 32 samples table[0..31] starting 1 cycle after handshake; symbol_done and burst_end high on sample 32; signal=128 on the next cycle.
- BPSK sym 1 followed back-to-back by sym 0 -> 64 contiguous valid samples: table[16..31,0..15] then table[0..31]; symbol_done on samples 32 and 64; burst_end only on 64.
- QPSK, mode=1, symbols 00, 01, 11, 10 back-to-back -> first samples table[0], table[8], table[16], table[24]; 128 contiguous valid samples.
- Assert rst at cnt=10 of a symbol -> signal=128 and sample_valid=0 immediately (before the next edge); after release, sym_ready=enable and a new symbol starts at cnt 0.
- enable dropped at cnt=5 with sym_valid held high -> current symbol completes all 32 samples; sym_ready=0 at cnt 31; burst_end=1; state returns to IDLE; no second symbol is accepted until enable returns.
